// File: rtl/imm_gen_pipe_if.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe_if
// Handshake bundle for the decode-stage immediate generator.
//   in_valid   : upstream beat valid                 (master -> slave)
//   in_ready   : generator can take a beat           (slave  -> master)
//   in_instr   : raw 32-bit instruction word         (master -> slave)
//   in_imm_src : immediate format select             (master -> slave)
//   in_tag     : sideband tag (PC / ROB id)          (master -> slave)
//   out_valid  : result beat valid                   (slave  -> master)
//   out_ready  : consumer accepts the result beat    (master -> slave)
//   out_imm    : extended immediate, XLEN bits       (slave  -> master)
//   out_tag    : tag travelling with out_imm         (slave  -> master)
//   out_err    : illegal format / reserved shamt     (slave  -> master)
// ---------------------------------------------------------------------------
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [2:0]       in_imm_src;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport master (
    output in_valid, in_instr, in_imm_src, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_instr, in_imm_src, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_err
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
// Registered RV32/RV64 immediate generator with valid/ready on both sides
// and a two-entry (main + skid) buffer. Every output is a flop.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : imm_gen_pipe_if.slave (in_* request side, out_* result side)
// Parameters:
//   XLEN  : 32 or 64, width every immediate is extended to
//   TAG_W : width of the sideband tag
// ---------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  imm_gen_pipe_if.slave  bus
);

  localparam logic [2:0] SRC_I     = 3'b000;
  localparam logic [2:0] SRC_S     = 3'b001;
  localparam logic [2:0] SRC_B     = 3'b010;
  localparam logic [2:0] SRC_J     = 3'b011;
  localparam logic [2:0] SRC_U     = 3'b100;
  localparam logic [2:0] SRC_SHAMT = 3'b101;
  localparam logic [2:0] SRC_ZIMM  = 3'b110;

  localparam bit IS_RV64 = (XLEN == 64);

  // ---------------- decode ----------------
  logic [31:0]     ins;
  logic [31:0]     imm32;
  logic [5:0]      zimm6;
  logic            use_zext;
  logic [XLEN-1:0] dec_imm;
  logic            dec_err;

  assign ins = bus.in_instr;

  always_comb begin
    imm32    = '0;
    zimm6    = '0;
    use_zext = 1'b0;
    dec_err  = 1'b0;
    case (bus.in_imm_src)
      SRC_I: imm32 = {{20{ins[31]}}, ins[31:20]};
      SRC_S: imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      SRC_B: imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      SRC_J: imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      SRC_U: imm32 = {ins[31:12], 12'b0};
      SRC_SHAMT: begin
        use_zext = 1'b1;
        if (IS_RV64) begin
          zimm6 = ins[25:20];
        end else begin
          // RV32 shifts are 5 bits; instr[25] set is a reserved encoding
          zimm6   = {1'b0, ins[24:20]};
          dec_err = ins[25];
        end
      end
      SRC_ZIMM: begin
        use_zext = 1'b1;
        zimm6    = {1'b0, ins[19:15]};
      end
      default: begin
        use_zext = 1'b1;
        dec_err  = 1'b1;
      end
    endcase

    // U is sign-extended from bit 31 as well, which gives RV64 lui/auipc semantics
    if (use_zext) begin
      dec_imm       = '0;
      dec_imm[5:0]  = zimm6;
    end else begin
      dec_imm       = {XLEN{imm32[31]}};
      dec_imm[31:0] = imm32;
    end
  end

  // ---------------- storage ----------------
  logic             main_valid;
  logic [XLEN-1:0]  main_imm;
  logic [TAG_W-1:0] main_tag;
  logic             main_err;

  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_err;

  logic             in_ready_r;
  logic             do_in;
  logic             main_free;
  logic             skid_valid_nxt;

  assign do_in     = bus.in_valid && in_ready_r;
  // main register can load this cycle: empty, or its beat is leaving now
  assign main_free = !main_valid || bus.out_ready;

  // skid only fills when main is occupied and stalled; any main drain empties it
  // (accept and skid-refill never coincide because in_ready is low while skid is full)
  assign skid_valid_nxt = main_free ? 1'b0 : (skid_valid || do_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_imm   <= '0;
      main_tag   <= '0;
      main_err   <= 1'b0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_tag   <= '0;
      skid_err   <= 1'b0;
      in_ready_r <= 1'b0;
    end else begin
      if (main_free) begin
        if (skid_valid) begin
          main_valid <= 1'b1;
          main_imm   <= skid_imm;
          main_tag   <= skid_tag;
          main_err   <= skid_err;
        end else if (do_in) begin
          main_valid <= 1'b1;
          main_imm   <= dec_imm;
          main_tag   <= bus.in_tag;
          main_err   <= dec_err;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (do_in) begin
        skid_imm <= dec_imm;
        skid_tag <= bus.in_tag;
        skid_err <= dec_err;
      end
      skid_valid <= skid_valid_nxt;
      in_ready_r <= !skid_valid_nxt;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = main_valid;
  assign bus.out_imm   = main_imm;
  assign bus.out_tag   = main_tag;
  assign bus.out_err   = main_err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (.clk(clk), .reset(reset), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (.clk(clk), .reset(reset), .bus(b64));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // reference: {err, imm64}; built from arithmetic shifts of the sign-extended word
  function automatic logic [64:0] ref_imm(input logic [31:0] ins, input logic [2:0] src, input int xlen);
    logic signed [63:0] s;
    logic [63:0] hi;
    logic [63:0] r;
    logic        e;
    s = {{32{ins[31]}}, ins};
    e = 1'b0;
    r = '0;
    case (src)
      3'd0: begin hi = s >>> 20; r = hi; end
      3'd1: begin hi = s >>> 25; r = (hi << 5) | 64'(ins[11:7]); end
      3'd2: begin hi = s >>> 31; r = (hi << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1); end
      3'd3: begin hi = s >>> 31; r = (hi << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1); end
      3'd4: begin hi = s >>> 12; r = hi << 12; end
      3'd5: begin
        if (xlen == 64) r = 64'(ins[25:20]);
        else begin r = 64'(ins[24:20]); e = ins[25]; end
      end
      3'd6: r = 64'(ins[19:15]);
      default: begin r = '0; e = 1'b1; end
    endcase
    if (xlen == 32) r = {32'b0, r[31:0]};
    return {e, r};
  endfunction

  task automatic idle_inputs();
    b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_imm_src = '0; b32.in_tag = '0; b32.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_imm_src = '0; b64.in_tag = '0; b64.out_ready = 1'b1;
  endtask

  // single beat through an idle block; returns {err, imm}
  task automatic one32(input string nm, input logic [31:0] ins, input logic [2:0] src,
                       input logic [31:0] tg, output logic [64:0] res);
    b32.in_valid = 1'b1; b32.in_instr = ins; b32.in_imm_src = src; b32.in_tag = tg; b32.out_ready = 1'b1;
    tick();
    b32.in_valid = 1'b0;
    check({nm, "_valid"}, b32.out_valid, 1'b1);
    check({nm, "_tag"}, b32.out_tag, tg);
    res = {b32.out_err, 32'b0, b32.out_imm};
    tick();
  endtask

  task automatic one64(input string nm, input logic [31:0] ins, input logic [2:0] src,
                       input logic [31:0] tg, output logic [64:0] res);
    b64.in_valid = 1'b1; b64.in_instr = ins; b64.in_imm_src = src; b64.in_tag = tg; b64.out_ready = 1'b1;
    tick();
    b64.in_valid = 1'b0;
    check({nm, "_valid"}, b64.out_valid, 1'b1);
    check({nm, "_tag"}, b64.out_tag, tg);
    res = {b64.out_err, b64.out_imm};
    tick();
  endtask

  logic [31:0] vi [5];
  logic [2:0]  vs [5];
  logic [31:0] ve [5];

  initial begin
    logic [64:0] res;
    logic [31:0] next_tag;
    logic [31:0] held_imm, held_tag;
    bit          have_held;
    bit          will_acc;
    int          acc;
    logic [31:0] dr_tag [$];
    logic [31:0] dr_imm [$];
    logic [64:0] q [$];
    logic [64:0] exp_beat, m;
    int          sent, got, cyc;
    bit          seen;

    vi = '{32'hFFF00093, 32'hFE112E23, 32'hFE000FE3, 32'h0010006F, 32'h800000B7};
    vs = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    ve = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFE, 32'h00000800, 32'h80000000};

    idle_inputs();
    reset = 1'b1;
    tick(); tick(); tick();
    check("rst_out_valid32", b32.out_valid, 1'b0);
    check("rst_in_ready32", b32.in_ready, 1'b0);
    check("rst_out_imm32", b32.out_imm, 32'h0);
    check("rst_out_tag32", b32.out_tag, 32'h0);
    check("rst_out_err32", b32.out_err, 1'b0);
    check("rst_out_valid64", b64.out_valid, 1'b0);
    check("rst_in_ready64", b64.in_ready, 1'b0);
    reset = 1'b0;
    tick();
    check("post_rst_in_ready32", b32.in_ready, 1'b1);
    check("post_rst_in_ready64", b64.in_ready, 1'b1);

    // back-to-back stream, out_ready high: one result per cycle, 1-cycle latency
    b32.out_ready = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) begin
        check("stream_valid", b32.out_valid, 1'b1);
        check("stream_imm", b32.out_imm, ve[k-1]);
        check("stream_tag", b32.out_tag, 32'd100 + 32'(k - 1));
        check("stream_err", b32.out_err, 1'b0);
      end
      if (k < 5) begin
        check("stream_in_ready", b32.in_ready, 1'b1);
        b32.in_valid = 1'b1; b32.in_instr = vi[k]; b32.in_imm_src = vs[k]; b32.in_tag = 32'd100 + 32'(k);
      end else begin
        b32.in_valid = 1'b0;
      end
      tick();
    end
    check("stream_idle", b32.out_valid, 1'b0);

    // RV64 and special formats
    one64("u64", 32'h800000B7, 3'd4, 32'h11, res);
    check("u64_imm", res, {1'b0, 64'hFFFFFFFF80000000});
    one64("shamt64", 32'h03F09093, 3'd5, 32'h12, res);
    check("shamt64_imm", res, {1'b0, 64'd63});
    one32("shamt32", 32'h03F09093, 3'd5, 32'h13, res);
    check("shamt32_imm", res, {1'b1, 64'h1F});
    one32("zimm32", 32'h340FD0F3, 3'd6, 32'h14, res);
    check("zimm32_imm", res, {1'b0, 64'h1F});
    one64("zimm64", 32'h340FD0F3, 3'd6, 32'h15, res);
    check("zimm64_imm", res, {1'b0, 64'h1F});
    one32("rsvd32", 32'h340FD0F3, 3'd7, 32'h16, res);
    check("rsvd32_imm", res, {1'b1, 64'h0});
    one64("b64", 32'hFE000FE3, 3'd2, 32'h17, res);
    check("b64_imm", res, {1'b0, 64'hFFFFFFFFFFFFFFFE});

    // back-pressure: 4 stalled cycles with tags 1,2,3 offered
    b32.out_ready = 1'b0;
    next_tag = 32'd1;
    acc = 0;
    have_held = 1'b0;
    held_imm = '0;
    held_tag = '0;
    for (int c = 0; c < 4; c++) begin
      b32.in_valid = 1'b1; b32.in_imm_src = 3'd0;
      b32.in_instr = (next_tag << 20) | 32'h13; b32.in_tag = next_tag;
      will_acc = b32.in_ready;
      if (will_acc) acc++;
      tick();
      if (will_acc) next_tag = next_tag + 32'd1;
      if (b32.out_valid) begin
        if (!have_held) begin
          have_held = 1'b1; held_imm = b32.out_imm; held_tag = b32.out_tag;
        end else begin
          check("stall_imm_stable", b32.out_imm, held_imm);
          check("stall_tag_stable", b32.out_tag, held_tag);
        end
      end
    end
    check("bp_accepted", acc, 2);
    check("bp_in_ready_low", b32.in_ready, 1'b0);
    check("bp_head_tag", b32.out_tag, 32'd1);

    b32.out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      b32.in_instr = (next_tag << 20) | 32'h13; b32.in_tag = next_tag;
      will_acc = b32.in_valid && b32.in_ready;
      if (b32.out_valid) begin
        dr_tag.push_back(b32.out_tag);
        dr_imm.push_back(b32.out_imm);
      end
      tick();
      if (will_acc) begin
        next_tag = next_tag + 32'd1;
        if (next_tag > 32'd3) b32.in_valid = 1'b0;
      end
    end
    check("drain_count", dr_tag.size(), 3);
    for (int i = 0; i < dr_tag.size() && i < 3; i++) begin
      check("drain_tag", dr_tag[i], 32'(i + 1));
      check("drain_imm", dr_imm[i], 32'(i + 1));
    end

    // random valid/ready against the reference model
    sent = 0; got = 0; cyc = 0;
    while (got < 1000 && cyc < 20000) begin
      b32.in_valid   = (sent < 1000) && ($urandom_range(0, 3) != 0);
      b32.in_instr   = $urandom;
      b32.in_imm_src = 3'($urandom_range(0, 7));
      b32.in_tag     = $urandom;
      b32.out_ready  = ($urandom_range(0, 3) != 0);
      if (b32.out_valid) begin
        if (q.size() == 0) begin
          check("rand_spurious_valid", 1'b1, 1'b0);
        end else if (b32.out_ready) begin
          exp_beat = q.pop_front();
          check("rand_beat", {b32.out_err, b32.out_tag, b32.out_imm}, exp_beat);
          got++;
        end
      end
      if (b32.in_valid && b32.in_ready) begin
        m = ref_imm(b32.in_instr, b32.in_imm_src, 32);
        q.push_back({m[64], b32.in_tag, m[31:0]});
        sent++;
      end
      tick();
      cyc++;
    end
    check("rand_all_drained", got, 1000);

    // reset while two beats are held
    b32.in_valid = 1'b0; b32.out_ready = 1'b1;
    tick(); tick(); tick();
    b32.out_ready = 1'b0;
    b32.in_valid = 1'b1; b32.in_imm_src = 3'd0; b32.in_instr = 32'h00700013; b32.in_tag = 32'd7;
    tick();
    b32.in_instr = 32'h00800013; b32.in_tag = 32'd8;
    tick();
    b32.in_valid = 1'b0;
    check("full_out_valid", b32.out_valid, 1'b1);
    check("full_in_ready", b32.in_ready, 1'b0);
    reset = 1'b1;
    tick();
    check("mid_rst_out_valid", b32.out_valid, 1'b0);
    check("mid_rst_in_ready", b32.in_ready, 1'b0);
    check("mid_rst_out_tag", b32.out_tag, 32'h0);
    reset = 1'b0;
    b32.out_ready = 1'b1;
    tick();
    check("after_rst_in_ready", b32.in_ready, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      seen = seen | b32.out_valid;
      tick();
    end
    check("no_stale_beat", seen, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, parametrised immediate generator for the decode stage of the pipelined RV32/RV64 core.
- Extracts and sign- or zero-extends the immediate for all RV32I/RV64I formats: I, S, B, J, U, shift-amount and CSR zimm.
- Each beat carries a passthrough tag (PC / ROB id) alongside the immediate.
- Valid/ready handshakes on input and output, with a 2-entry skid buffer, so decode back-pressure never corrupts or drops an immediate.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. Every immediate is extended to XLEN.
- TAG_W, 32, width of the sideband tag carried with each immediate.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_instr  input  32  raw instruction word
- in_imm_src  input  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 SHAMT, 110 ZIMM, 111 reserved
- in_tag  input  TAG_W  sideband carried unchanged with the beat
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts the beat
- out_imm  output  XLEN  extended immediate
- out_tag  output  TAG_W  tag of the beat on out_imm
- out_err  output  1  the beat has an illegal format or a reserved shift amount

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: out_valid=0, out_imm=0, out_tag=0, out_err=0, skid buffer empty.
  - in_ready=0 while reset is high.
  - in_ready=1 from the first cycle after reset deasserts.
  - Reset mid-transfer discards all held beats; nothing is emitted afterwards.
- Transfer rules: an input beat is accepted when in_valid&&in_ready; an output beat completes when out_valid&&out_ready.
- Formats, sign bit instr[31], extended to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25],instr[11:7]}.
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],0}.
  - U: {instr[31:12],12'b0}, sign-extended (RV64 semantics).
  - SHAMT: zero-extended. XLEN=64 uses instr[25:20]. XLEN=32 uses instr[24:20], and out_err=1 if instr[25]=1.
  - ZIMM: zero-extended instr[19:15].
  - 111: imm=0, out_err=1.
- Storage: a main output register plus one skid register. Capacity is 2 beats. Order is strictly FIFO.
- Latency: exactly 1 cycle from acceptance to out_valid when the block was empty. With out_ready held high, throughput is 1 beat/cycle.
- in_ready is a registered signal, equal to !skid_valid. It must not combinationally depend on out_ready.
- Accept with the main register empty, or with the main register draining this cycle: the beat goes into the main register.
- Accept with the main register full and stalled: the beat goes into the skid register, and in_ready drops next cycle.
- Skid register full when the main register drains: the skid beat moves into the main register and in_ready rises next cycle.
- Stability: while out_valid&&!out_ready, out_imm, out_tag and out_err hold stable.
- Simultaneous accept and drain with the skid register full cannot occur, because in_ready=0 in that state.
- No combinational path from any input to out_*. Everything is registered.

Test Plan:
- XLEN=32, stream with out_ready=1:
  - I 0xFFF00093 -> 0xFFFFFFFF
  - S 0xFE112E23 -> 0xFFFFFFFC
  - B 0xFE000FE3 -> 0xFFFFFFFE
  - J 0x0010006F -> 0x00000800
  - U 0x800000B7 -> 0x80000000
  - Each result appears 1 cycle after acceptance, tags preserved, one result per cycle.
- XLEN=64:
  - U 0x800000B7 -> 0xFFFFFFFF80000000.
  - SHAMT 0x03F09093 -> 63, out_err=0.
  - With XLEN=32 the same SHAMT word gives out_err=1.
- ZIMM csrrwi with instr[19:15]=31 -> 0x1F, zero-extended. in_imm_src=111 -> imm=0, out_err=1.
- Back-pressure: hold out_ready=0 for 4 cycles while in_valid=1 with tags 1,2,3.
  - Exactly 2 beats are accepted, then in_ready=0.
  - out_imm and out_tag stay stable during the stall.
  - On releasing out_ready, tags 1,2,3 drain in order with no loss or duplication.
- Random valid/ready toggling over 1000 beats vs a reference model: outputs match in order; no out_valid without a prior accepted beat.
- Assert reset while 2 beats are held: the next cycle shows out_valid=0 and in_ready=0. After deassert in_ready=1, and no stale beat ever appears.
